// File: rtl/hack_cpu_mc_if.sv
// Memory-side bus of the multi-cycle Hack CPU: one instruction fetch channel
// and one data channel. The CPU is the master; the memory system is the slave.
//
// Handshake (both channels): the master raises *_req together with address
// (and, for data writes, dmem_we/dmem_wdata) and holds all of them stable
// until it samples *_ack high on a rising edge. The slave pulses *_ack for
// one cycle; for reads *_rdata is valid in that same ack cycle. An ack seen
// while the matching request is low is ignored.
interface hack_cpu_mc_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WIDTH-1:0]  imem_rdata;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [WIDTH-1:0]  dmem_wdata;
    logic              dmem_ack;
    logic [WIDTH-1:0]  dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction and data memories.
// FSM: FETCH -> EXEC [-> MREAD -> EXEC] [-> MWRITE] -> FETCH.
// Optional feature: define HACK_CPU_MC_ILLEGAL_TRAP_EN to trap C-instructions
// whose IR[14:13] is not 2'b11 into a HALT state (sticky illegal flag).
// Without the macro IR[14:13] is ignored and illegal is tied low.
module hack_cpu_mc #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    hack_cpu_mc_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic [WIDTH-1:0]  a_out,
    output logic [WIDTH-1:0]  d_out,
    output logic              retire,
    output logic              illegal,
    output logic [2:0]        state_dbg
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_EXEC   = 3'd1;
    localparam logic [2:0] S_MREAD  = 3'd2;
    localparam logic [2:0] S_MWRITE = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]        state;
    logic [WIDTH-1:0]  ir;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  d_reg;
    logic [WIDTH-1:0]  mdr;
    logic              mdr_valid;   // MDR holds the operand for the current IR
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    logic [WIDTH-1:0]  alu_x;
    logic [WIDTH-1:0]  alu_y;
    logic [WIDTH-1:0]  alu_out;
    logic              zr;
    logic              ng;
    logic              jump;
    logic              illegal_op;

    // Hack ALU with x = D, y = A or M, plus the jump decision on zr/ng.
    always_comb begin
        alu_x = d_reg;
        alu_y = ir[12] ? mdr : a_reg;
        if (ir[11]) alu_x = '0;
        if (ir[10]) alu_x = ~alu_x;
        if (ir[9])  alu_y = '0;
        if (ir[8])  alu_y = ~alu_y;
        alu_out = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ir[6])  alu_out = ~alu_out;
        zr   = (alu_out == '0);
        ng   = alu_out[WIDTH-1];
        jump = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
    end

`ifdef HACK_CPU_MC_ILLEGAL_TRAP_EN
    assign illegal_op = ir[WIDTH-1] & (ir[14:13] != 2'b11);
`else
    assign illegal_op = 1'b0;
`endif

    // Control sequencing and architectural register updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= '0;
            a_reg     <= '0;
            d_reg     <= '0;
            ir        <= '0;
            mdr       <= '0;
            mdr_valid <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            retire    <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        ir        <= bus.imem_rdata;
                        mdr_valid <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!ir[WIDTH-1]) begin
                        a_reg  <= {1'b0, ir[WIDTH-2:0]};
                        pc     <= pc + ADDR_W'(1);
                        retire <= 1'b1;
                        state  <= S_FETCH;
                    end else if (illegal_op) begin
                        state <= S_HALT;
                    end else if (ir[12] && !mdr_valid) begin
                        state <= S_MREAD;
                    end else begin
                        // Jump target and M address both use A before this update.
                        pc    <= jump ? a_reg[ADDR_W-1:0] : pc + ADDR_W'(1);
                        waddr <= a_reg[ADDR_W-1:0];
                        wdata <= alu_out;
                        if (ir[5]) a_reg <= alu_out;
                        if (ir[4]) d_reg <= alu_out;
                        if (ir[3]) begin
                            state <= S_MWRITE;
                        end else begin
                            retire <= 1'b1;
                            state  <= S_FETCH;
                        end
                    end
                end
                S_MREAD: begin
                    if (bus.dmem_ack) begin
                        mdr       <= bus.dmem_rdata;
                        mdr_valid <= 1'b1;
                        state     <= S_EXEC;
                    end
                end
                S_MWRITE: begin
                    if (bus.dmem_ack) begin
                        retire <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef HACK_CPU_MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)                 illegal_q <= 1'b0;
        else if (state == S_HALT)  illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign bus.imem_req   = (state == S_FETCH);
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = (state == S_MREAD) || (state == S_MWRITE);
    assign bus.dmem_we    = (state == S_MWRITE);
    assign bus.dmem_addr  = (state == S_MWRITE) ? waddr : a_reg[ADDR_W-1:0];
    assign bus.dmem_wdata = wdata;

    assign a_out     = a_reg;
    assign d_out     = d_reg;
    assign state_dbg = state;
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: small Hack programs with a bench-side data
// memory that serves the handshakes and records every transaction.
module tb_hack_cpu_mc;
    logic        clk;
    logic        reset;
    logic [14:0] pc;
    logic [15:0] a_out;
    logic [15:0] d_out;
    logic        retire;
    logic        illegal;
    logic [2:0]  state_dbg;

    hack_cpu_mc_if #(.WIDTH(16), .ADDR_W(15)) bus ();

    hack_cpu_mc #(.WIDTH(16), .ADDR_W(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pc        (pc),
        .a_out     (a_out),
        .d_out     (d_out),
        .retire    (retire),
        .illegal   (illegal),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int fails  = 0;
    int stable_err  = 0;
    int overlap_err = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [14:0] last_raddr;
    logic [14:0] last_waddr;
    logic [15:0] last_wdata;
    bit   [15:0] mem [0:32767];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Driver: serve one instruction fetch, optionally delaying the ack.
    task automatic fetch(input logic [15:0] instr, input int delay);
        int n;
        logic [14:0] a0;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req) begin
            checks++; fails++;
            $display("FAIL fetch_timeout: imem_req=%0b required 1", bus.imem_req);
        end
        a0 = bus.imem_addr;
        repeat (delay) begin
            @(negedge clk);
            if (bus.imem_addr !== a0 || bus.imem_req !== 1'b1) stable_err++;
        end
        bus.imem_rdata = instr;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
    endtask

    // Driver: run after fetch until retire, serving data requests from mem.
    task automatic finish_instr();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.imem_req && bus.dmem_req) overlap_err++;
            if (retire) begin
                ok = 1'b1;
            end else if (bus.dmem_req) begin
                if (bus.dmem_we) begin
                    wr_cnt++;
                    last_waddr = bus.dmem_addr;
                    last_wdata = bus.dmem_wdata;
                    mem[bus.dmem_addr] = bus.dmem_wdata;
                end else begin
                    rd_cnt++;
                    last_raddr = bus.dmem_addr;
                    bus.dmem_rdata = mem[bus.dmem_addr];
                end
                bus.dmem_ack = 1'b1;
                @(negedge clk);
                bus.dmem_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL retire_timeout: retire=%0b required 1", retire);
        end
    endtask

    task automatic step(input logic [15:0] instr);
        fetch(instr, 0);
        finish_instr();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 15'd0 || a_out !== 16'd0 || d_out !== 16'd0) begin
            fails++;
            $display("FAIL reset_regs: pc=%h a=%h d=%h required 0", pc, a_out, d_out);
        end
        checks++;
        if (retire !== 1'b0 || illegal !== 1'b0 || state_dbg !== 3'd0) begin
            fails++;
            $display("FAIL reset_flags: retire=%b illegal=%b state=%0d required 0 0 0", retire, illegal, state_dbg);
        end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.dmem_req !== 1'b0 || bus.imem_addr !== 15'd0) begin
            fails++;
            $display("FAIL reset_bus: imem_req=%b dmem_req=%b imem_addr=%h required 1 0 0",
                     bus.imem_req, bus.dmem_req, bus.imem_addr);
        end
    endtask

    task automatic test_a_instr();
        fetch(16'h0005, 3);
        finish_instr();
        checks++;
        if (stable_err !== 0) begin
            fails++;
            $display("FAIL fetch_stable: %0d unstable cycles required 0", stable_err);
        end
        checks++;
        if (a_out !== 16'd5 || pc !== 15'd1) begin
            fails++;
            $display("FAIL a_instr: a=%h pc=%h required 0005 0001", a_out, pc);
        end
    endtask

    task automatic test_store();
        step(16'h0007);   // @7
        step(16'hEC10);   // D=A
        step(16'h0064);   // @100
        step(16'hE308);   // M=D
        checks++;
        if (wr_cnt !== 1 || rd_cnt !== 0) begin
            fails++;
            $display("FAIL store_count: wr=%0d rd=%0d required 1 0", wr_cnt, rd_cnt);
        end
        checks++;
        if (last_waddr !== 15'd100 || last_wdata !== 16'd7) begin
            fails++;
            $display("FAIL store_data: addr=%0d data=%h required 100 0007", last_waddr, last_wdata);
        end
        checks++;
        if (d_out !== 16'd7 || pc !== 15'd5) begin
            fails++;
            $display("FAIL store_regs: d=%h pc=%0d required 0007 5", d_out, pc);
        end
    endtask

    task automatic test_rmw();
        mem[100] = 16'hFFFF;
        rd_cnt = 0;
        wr_cnt = 0;
        step(16'hFDE8);   // AM=M+1 with A=100
        checks++;
        if (rd_cnt !== 1 || last_raddr !== 15'd100) begin
            fails++;
            $display("FAIL rmw_read: rd=%0d addr=%0d required 1 100", rd_cnt, last_raddr);
        end
        checks++;
        if (wr_cnt !== 1 || last_waddr !== 15'd100 || last_wdata !== 16'h0000) begin
            fails++;
            $display("FAIL rmw_write: wr=%0d addr=%0d data=%h required 1 100 0000", wr_cnt, last_waddr, last_wdata);
        end
        checks++;
        if (a_out !== 16'd0 || mem[100] !== 16'h0000) begin
            fails++;
            $display("FAIL rmw_result: a=%h mem=%h required 0000 0000", a_out, mem[100]);
        end
    endtask

    task automatic test_jump();
        step(16'hEA90);   // D=0
        step(16'h0014);   // @20
        step(16'hE302);   // D;JEQ taken
        checks++;
        if (pc !== 15'd20) begin
            fails++;
            $display("FAIL jeq_taken: pc=%0d required 20", pc);
        end
        step(16'hEFD0);   // D=1  (pc 21)
        step(16'h0014);   // @20  (pc 22)
        step(16'hE302);   // D;JEQ not taken (pc 23)
        checks++;
        if (pc !== 15'd23 || d_out !== 16'd1) begin
            fails++;
            $display("FAIL jeq_not_taken: pc=%0d d=%h required 23 0001", pc, d_out);
        end
        step(16'h001E);   // @30
        step(16'hE301);   // D;JGT taken
        checks++;
        if (pc !== 15'd30) begin
            fails++;
            $display("FAIL jgt_taken: pc=%0d required 30", pc);
        end
        step(16'h7FFF);   // @32767
        step(16'hEA87);   // 0;JMP
        checks++;
        if (pc !== 15'h7FFF) begin
            fails++;
            $display("FAIL jmp_max: pc=%h required 7fff", pc);
        end
        step(16'h0005);   // @5 at the top address, pc wraps
        checks++;
        if (pc !== 15'd0 || a_out !== 16'd5) begin
            fails++;
            $display("FAIL pc_wrap: pc=%h a=%h required 0000 0005", pc, a_out);
        end
    endtask

    task automatic test_reset_mwrite();
        int n;
        int rcnt;
        step(16'h0007);   // @7
        step(16'hEC10);   // D=A
        step(16'h0064);   // @100
        fetch(16'hE308, 0);   // M=D, then abandon the write
        n = 0;
        while (!(bus.dmem_req && bus.dmem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
            fails++;
            $display("FAIL mwrite_reach: req=%b we=%b required 1 1", bus.dmem_req, bus.dmem_we);
        end
        @(negedge clk);
        reset        = 1'b1;
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.dmem_ack = 1'b0;
        checks++;
        if (retire !== 1'b0 || pc !== 15'd0 || a_out !== 16'd0 || d_out !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid: retire=%b pc=%h a=%h d=%h required 0 0 0 0", retire, pc, a_out, d_out);
        end
        checks++;
        if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 15'd0) begin
            fails++;
            $display("FAIL reset_mid_bus: dreq=%b we=%b ireq=%b iaddr=%h required 0 0 1 0",
                     bus.dmem_req, bus.dmem_we, bus.imem_req, bus.imem_addr);
        end
        rcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (retire) rcnt++;
        end
        checks++;
        if (rcnt !== 0 || state_dbg !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_idle: retires=%0d state=%0d required 0 0", rcnt, state_dbg);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        step(16'h0007);   // @7
        step(16'hEC10);   // D=A
`ifdef HACK_CPU_MC_ILLEGAL_TRAP_EN
        begin
            int ireq;
            int other;
            fetch(16'h8000, 0);
            ireq  = 0;
            other = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.imem_req) ireq++;
                if (bus.dmem_req || retire) other++;
            end
            checks++;
            if (illegal !== 1'b1 || state_dbg !== 3'd4) begin
                fails++;
                $display("FAIL trap_flag: illegal=%b state=%0d required 1 4", illegal, state_dbg);
            end
            checks++;
            if (ireq !== 0 || other !== 0 || d_out !== 16'd7 || pc !== 15'd2) begin
                fails++;
                $display("FAIL trap_quiet: ireq=%0d other=%0d d=%h pc=%0d required 0 0 0007 2",
                         ireq, other, d_out, pc);
            end
            do_reset();
        end
`else
        step(16'h8000);   // D&A, no dest, no jump
        checks++;
        if (illegal !== 1'b0 || d_out !== 16'd7 || pc !== 15'd3) begin
            fails++;
            $display("FAIL no_trap: illegal=%b d=%h pc=%0d required 0 0007 3", illegal, d_out, pc);
        end
`endif
    endtask

    // Sequencer and final report
    initial begin
        reset          = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_a_instr();
        test_store();
        test_rmw();
        test_jump();
        test_reset_mwrite();
        test_illegal();
        checks++;
        if (overlap_err !== 0) begin
            fails++;
            $display("FAIL req_overlap: %0d cycles with both requests required 0", overlap_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 Parameter WIDTH, default 16, data path and register width (minimum 16).
REQ-002 Parameter ADDR_W, default 15, instruction and data address width (at most WIDTH-1).
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port imem_req / imem_addr / imem_ack / imem_rdata, out 1 / out ADDR_W / in 1 / in WIDTH, instruction fetch handshake.
REQ-006 Port dmem_req / dmem_we / dmem_addr / dmem_wdata, out 1 / out 1 / out ADDR_W / out WIDTH, data request.
REQ-007 Port dmem_ack / dmem_rdata, in 1 / in WIDTH, data completion and read data.
REQ-008 Port pc / a_out / d_out, out ADDR_W / out WIDTH / out WIDTH, architectural PC, A and D.
REQ-009 Port retire, out 1, one-cycle pulse when an instruction completes.
REQ-010 Port illegal, out 1, sticky illegal-instruction flag (see Configuration).

Function
REQ-011 The FSM SHALL use states FETCH, EXEC, MREAD, MWRITE and HALT.
REQ-012 FETCH: imem_req=1 and imem_addr=pc held stable until imem_ack; on ack, latch imem_rdata into IR and go to EXEC.
REQ-013 A-instruction (IR[WIDTH-1]=0): EXEC loads A with zero-extended IR[WIDTH-2:0], sets pc=pc+1, pulses retire and goes to FETCH.
REQ-014 C-instruction with a-bit IR[12]=1: EXEC goes to MREAD; dmem_req=1, dmem_we=0, dmem_addr=A[ADDR_W-1:0] held until dmem_ack; latch dmem_rdata into MDR, then re-enter EXEC to compute.
REQ-015 ALU: Hack semantics with x=D, y=(IR[12] ? MDR : A), and controls zx,nx,zy,ny,f,no = IR[11:6]; the result is WIDTH bits; zr = (out==0), ng = out[WIDTH-1].
REQ-016 Destinations IR[5:3] = A,D,M; A and D update at the end of compute; the M write uses the pre-update A as address and the ALU result as data, both latched.
REQ-017 If dest M is set, go to MWRITE: dmem_req=1, dmem_we=1, held stable until dmem_ack, then retire and go to FETCH; otherwise retire directly from EXEC.
REQ-018 Jump IR[2:0] uses the standard Hack JGT..JMP conditions on zr/ng; a taken jump loads pc with the pre-update A[ADDR_W-1:0], otherwise pc increments.
REQ-019 PC increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-020 Minimum latency: A-instruction 2 cycles, C-instruction without M 2 cycles, M read or M write adds 1 cycle each beyond the ack wait.
REQ-021 imem_req and dmem_req are never asserted in the same cycle; an ack outside its matching request state SHALL be ignored.
REQ-022 Read-modify-write (M=M+1) SHALL perform MREAD then MWRITE to the same latched address.

Reset
REQ-023 While reset is high at a clock edge: pc, A, D, IR and MDR become 0, illegal=0, retire=0, and the state becomes FETCH.
REQ-024 Reset mid-transaction abandons it; any ack sampled in a reset cycle is ignored, and dmem_req/dmem_we are 0 from the first post-reset cycle.

Configuration
REQ-025 Macro HACK_CPU_MC_ILLEGAL_TRAP_EN defined: a C-instruction with IR[14:13]!=2'b11 enters HALT in EXEC with no register, PC or memory update and no retire; HALT sets illegal=1, issues no requests and exits only on reset.
REQ-026 Macro undefined: IR[14:13] is ignored, HALT is unreachable, and illegal is tied to 0.

Verification
REQ-027 Fetch @5 (0x0005) with imem_ack delayed 3 cycles -> imem_addr stable for the whole wait; a_out=5 and pc=1 after retire.
REQ-028 Program @7, D=A, @100, M=D -> write dmem_addr=100 with wdata=7, dmem_we=1 for exactly one handshake; d_out=7.
REQ-029 A=100 with mem[100]=0xFFFF, execute AM=M+1 -> read addr 100, write addr 100 with data 0, then a_out=0.
REQ-030 D=0, A=20, D;JEQ -> pc=20; repeat with D=1 -> pc increments; pc=0x7FFF with no jump -> pc=0.
REQ-031 Assert reset during an MWRITE wait with dmem_ack arriving in the reset cycle -> no retire; all registers 0; FETCH at pc=0.
REQ-032 With HACK_CPU_MC_ILLEGAL_TRAP_EN, fetch 0x8000 -> illegal=1, no further imem_req, D unchanged; without the macro, the same instruction executes as a normal C-instruction.
